// File: rtl/reorder_buffer_pkg.sv
// Shared configuration for the reorder buffer: default widths, bus types
// and the reserved "no producer" nick.
package reorder_buffer_pkg;

    localparam int unsigned CFG_DEPTH  = 16;
    localparam int unsigned CFG_NICK_W = 5;
    localparam int unsigned CFG_DATA_W = 32;
    localparam int unsigned CFG_REG_W  = 5;

    typedef logic [CFG_NICK_W-1:0] NickBus;
    typedef logic [CFG_DATA_W-1:0] DataBus;
    typedef logic [CFG_REG_W-1:0]  NameBus;

    // Nick 0 never names an entry: it marks a register with no pending producer.
    localparam NickBus NICK_NONE = '0;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. Allocates a nick per dispatch, captures
// CDB results, retires the head in program order, and flushes everything on
// a mispredicted branch at the head.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = CFG_DEPTH,
    parameter int unsigned NICK_W = CFG_NICK_W,
    parameter int unsigned DATA_W = CFG_DATA_W,
    parameter int unsigned REG_W  = CFG_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iDP_en,
    input  logic [REG_W-1:0]  iDP_rd_regnm,
    input  logic              iDP_wr_rd,
    input  logic              iDP_is_br,
    input  logic              iDP_pd,
    input  logic              iDP_is_st,
    output logic [NICK_W-1:0] oDP_nick,
    output logic              oDP_full,
    output logic              oRF_nick_en,
    output logic [REG_W-1:0]  oRF_nick_regnm,
    output logic [NICK_W-1:0] oRF_nick,
    input  logic              iCDB_en,
    input  logic [NICK_W-1:0] iCDB_nick,
    input  logic [DATA_W-1:0] iCDB_dt,
    input  logic              iCDB_tk,
    input  logic [DATA_W-1:0] iCDB_tgt,
    output logic              oRF_en,
    output logic [REG_W-1:0]  oRF_rd_regnm,
    output logic [DATA_W-1:0] oRF_rd_dt,
    output logic [NICK_W-1:0] oRF_rd_nick,
    output logic              oLSB_st_en,
    output logic [NICK_W-1:0] oLSB_st_nick,
    output logic              oclr,
    output logic [DATA_W-1:0] oIF_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Per-entry payload; busy/ready live in separate reset vectors.
    typedef struct packed {
        logic              wr_rd;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] dt;
        logic              is_br;
        logic              pd;
        logic              tk;
        logic [DATA_W-1:0] tgt;
        logic              is_st;
    } payload_t;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    payload_t         ent [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    // Registered commit/flush outputs; pulses are additionally gated by rdy.
    logic              rf_en_q;
    logic [REG_W-1:0]  rf_rd_regnm_q;
    logic [DATA_W-1:0] rf_rd_dt_q;
    logic [NICK_W-1:0] rf_rd_nick_q;
    logic              st_en_q;
    logic [NICK_W-1:0] st_nick_q;
    logic              clr_q;
    logic [DATA_W-1:0] pc_q;

    logic              alloc;
    logic              cdb_hit;
    logic [PTR_W-1:0]  cdb_slot;
    logic              commit;
    logic              mispredict;
    logic              rf_write;
    logic [NICK_W-1:0] head_nick;
    payload_t          head_ent;

    // Dispatch handshake, CDB slot lookup and head commit decision.
    always_comb begin
        oDP_full       = (count == CNT_W'(DEPTH));
        // clr_q doubles as the one-cycle post-flush allocation block.
        alloc          = rdy & iDP_en & ~oDP_full & ~clr_q;
        oDP_nick       = NICK_W'(tail) + NICK_W'(1);
        oRF_nick_en    = alloc & iDP_wr_rd & (iDP_rd_regnm != '0);
        oRF_nick_regnm = iDP_rd_regnm;
        oRF_nick       = oDP_nick;

        cdb_slot = PTR_W'(iCDB_nick - NICK_W'(1));
        cdb_hit  = rdy & iCDB_en
                 & (iCDB_nick != NICK_W'(NICK_NONE))
                 & (iCDB_nick <= NICK_W'(DEPTH))
                 & busy[cdb_slot];

        head_ent   = ent[head];
        head_nick  = NICK_W'(head) + NICK_W'(1);
        commit     = rdy & busy[head] & ready[head];
        mispredict = commit & head_ent.is_br & (head_ent.tk != head_ent.pd);
        rf_write   = head_ent.wr_rd & (head_ent.rd != '0);
    end

    // Pulse outputs are suppressed while frozen; data outputs just hold.
    always_comb begin
        oRF_en       = rf_en_q & rdy;
        oRF_rd_regnm = rf_rd_regnm_q;
        oRF_rd_dt    = rf_rd_dt_q;
        oRF_rd_nick  = rf_rd_nick_q;
        oLSB_st_en   = st_en_q & rdy;
        oLSB_st_nick = st_nick_q;
        oclr         = clr_q & rdy;
        oIF_pc       = pc_q;
    end

    // Control state: occupancy, pointers, count and registered commit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= '0;
            ready         <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            rf_en_q       <= 1'b0;
            rf_rd_regnm_q <= '0;
            rf_rd_dt_q    <= '0;
            rf_rd_nick_q  <= '0;
            st_en_q       <= 1'b0;
            st_nick_q     <= '0;
            clr_q         <= 1'b0;
            pc_q          <= '0;
        end else if (!rdy) begin
            rf_en_q <= 1'b0;
            st_en_q <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            rf_en_q <= 1'b0;
            st_en_q <= 1'b0;
            clr_q   <= 1'b0;

            if (alloc) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= iDP_is_st;
                tail        <= tail + PTR_W'(1);
            end

            if (cdb_hit) begin
                ready[cdb_slot] <= 1'b1;
            end

            if (commit) begin
                busy[head]    <= 1'b0;
                ready[head]   <= 1'b0;
                head          <= head + PTR_W'(1);
                rf_en_q       <= rf_write;
                rf_rd_regnm_q <= head_ent.rd;
                rf_rd_dt_q    <= head_ent.dt;
                rf_rd_nick_q  <= head_nick;
                st_en_q       <= head_ent.is_st;
                st_nick_q     <= head_nick;
            end

            case ({alloc, commit})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Flush overrides this cycle's allocation and pointer updates.
            if (mispredict) begin
                busy  <= '0;
                ready <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
                clr_q <= 1'b1;
                pc_q  <= head_ent.tgt;
            end
        end
    end

    // Entry payload: allocation fields and CDB result fields never overlap.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (alloc) begin
                ent[tail].wr_rd <= iDP_wr_rd;
                ent[tail].rd    <= iDP_rd_regnm;
                ent[tail].is_br <= iDP_is_br;
                ent[tail].pd    <= iDP_pd;
                ent[tail].is_st <= iDP_is_st;
            end
            if (cdb_hit) begin
                ent[cdb_slot].dt  <= iCDB_dt;
                ent[cdb_slot].tk  <= iCDB_tk;
                ent[cdb_slot].tgt <= iCDB_tgt;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a vector table for the basic
// dispatch/complete/commit flow, hand-written sequences for reset, fill and
// wrap, freeze and flush, and a commit scoreboard checked every cycle.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned NICK_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              iDP_en;
    logic [REG_W-1:0]  iDP_rd_regnm;
    logic              iDP_wr_rd;
    logic              iDP_is_br;
    logic              iDP_pd;
    logic              iDP_is_st;
    logic [NICK_W-1:0] oDP_nick;
    logic              oDP_full;
    logic              oRF_nick_en;
    logic [REG_W-1:0]  oRF_nick_regnm;
    logic [NICK_W-1:0] oRF_nick;
    logic              iCDB_en;
    logic [NICK_W-1:0] iCDB_nick;
    logic [DATA_W-1:0] iCDB_dt;
    logic              iCDB_tk;
    logic [DATA_W-1:0] iCDB_tgt;
    logic              oRF_en;
    logic [REG_W-1:0]  oRF_rd_regnm;
    logic [DATA_W-1:0] oRF_rd_dt;
    logic [NICK_W-1:0] oRF_rd_nick;
    logic              oLSB_st_en;
    logic [NICK_W-1:0] oLSB_st_nick;
    logic              oclr;
    logic [DATA_W-1:0] oIF_pc;

    reorder_buffer #(
        .DEPTH (DEPTH),
        .NICK_W(NICK_W),
        .DATA_W(DATA_W),
        .REG_W (REG_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .iDP_en        (iDP_en),
        .iDP_rd_regnm  (iDP_rd_regnm),
        .iDP_wr_rd     (iDP_wr_rd),
        .iDP_is_br     (iDP_is_br),
        .iDP_pd        (iDP_pd),
        .iDP_is_st     (iDP_is_st),
        .oDP_nick      (oDP_nick),
        .oDP_full      (oDP_full),
        .oRF_nick_en   (oRF_nick_en),
        .oRF_nick_regnm(oRF_nick_regnm),
        .oRF_nick      (oRF_nick),
        .iCDB_en       (iCDB_en),
        .iCDB_nick     (iCDB_nick),
        .iCDB_dt       (iCDB_dt),
        .iCDB_tk       (iCDB_tk),
        .iCDB_tgt      (iCDB_tgt),
        .oRF_en        (oRF_en),
        .oRF_rd_regnm  (oRF_rd_regnm),
        .oRF_rd_dt     (oRF_rd_dt),
        .oRF_rd_nick   (oRF_rd_nick),
        .oLSB_st_en    (oLSB_st_en),
        .oLSB_st_nick  (oLSB_st_nick),
        .oclr          (oclr),
        .oIF_pc        (oIF_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic        wr;
        logic        br;
        logic        pd;
        logic        st;
        logic        cen;
        logic [4:0]  cnick;
        logic [31:0] cdt;
        logic        ctk;
        logic [31:0] ctgt;
        logic [4:0]  exp_nick;
        logic        exp_full;
        logic        exp_nen;
    } vec_t;

    typedef struct {
        logic       st;
        logic [4:0] rd;
        logic [4:0] nick;
    } sb_t;

    vec_t        tbl[$];
    sb_t         sb[$];
    logic [31:0] model_dt [32];
    int unsigned tests    = 0;
    int unsigned fails    = 0;
    int unsigned clr_seen = 0;
    logic        clr_ok   = 1'b0;

    function automatic vec_t mk(input int unsigned en, rd, wr, br, pd, st,
                                input int unsigned cen, cnick, cdt, ctk, ctgt,
                                input int unsigned enick, efull, enen);
        vec_t v;
        v.en = en[0]; v.rd = rd[4:0]; v.wr = wr[0]; v.br = br[0];
        v.pd = pd[0]; v.st = st[0];
        v.cen = cen[0]; v.cnick = cnick[4:0]; v.cdt = cdt; v.ctk = ctk[0];
        v.ctgt = ctgt;
        v.exp_nick = enick[4:0]; v.exp_full = efull[0]; v.exp_nen = enen[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        iDP_en = 1'b0; iDP_rd_regnm = '0; iDP_wr_rd = 1'b0; iDP_is_br = 1'b0;
        iDP_pd = 1'b0; iDP_is_st = 1'b0;
        iCDB_en = 1'b0; iCDB_nick = '0; iCDB_dt = '0; iCDB_tk = 1'b0; iCDB_tgt = '0;
    endtask

    task automatic drive(input vec_t v);
        iDP_en = v.en; iDP_rd_regnm = v.rd; iDP_wr_rd = v.wr; iDP_is_br = v.br;
        iDP_pd = v.pd; iDP_is_st = v.st;
        iCDB_en = v.cen; iCDB_nick = v.cnick; iCDB_dt = v.cdt; iCDB_tk = v.ctk;
        iCDB_tgt = v.ctgt;
        if (v.cen) model_dt[v.cnick] = v.cdt;
    endtask

    task automatic dispatch(input int unsigned rd, input logic wr, br, pd, st);
        idle_inputs();
        iDP_en = 1'b1; iDP_rd_regnm = rd[4:0]; iDP_wr_rd = wr; iDP_is_br = br;
        iDP_pd = pd; iDP_is_st = st;
    endtask

    task automatic cdb(input int unsigned nick, input logic [31:0] dt, input logic tk,
                       input logic [31:0] tgt);
        idle_inputs();
        iCDB_en = 1'b1; iCDB_nick = nick[4:0]; iCDB_dt = dt; iCDB_tk = tk; iCDB_tgt = tgt;
        model_dt[nick[4:0]] = dt;
    endtask

    task automatic push(input logic st, input int unsigned rd, input int unsigned nick);
        sb_t e;
        e.st = st; e.rd = rd[4:0]; e.nick = nick[4:0];
        sb.push_back(e);
    endtask

    // Compare any commit or flush pulse visible this cycle against the scoreboard.
    task automatic monitor();
        sb_t e;
        if (oRF_en || oLSB_st_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", 32'({oRF_en, oLSB_st_en}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("commit_is_store", 32'(oLSB_st_en), 32'(e.st));
                if (e.st) begin
                    chk("store_nick", 32'(oLSB_st_nick), 32'(e.nick));
                    chk("store_no_rf_write", 32'(oRF_en), 32'd0);
                end else begin
                    chk("commit_rd", 32'(oRF_rd_regnm), 32'(e.rd));
                    chk("commit_nick", 32'(oRF_rd_nick), 32'(e.nick));
                    chk("commit_dt", oRF_rd_dt, model_dt[e.nick]);
                end
            end
        end
        if (oclr) begin
            if (!clr_ok) chk("spurious_clr", 32'(oclr), 32'd0);
            clr_seen++;
            sb.delete();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int unsigned n);
        for (int unsigned i = 0; i < n && sb.size() != 0; i++) tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset(input logic with_rdy);
        idle_inputs();
        rst = 1'b1; rdy = with_rdy;
        sb.delete();
        tick();
        rst = 1'b0; rdy = 1'b1;
    endtask

    initial begin
        int unsigned n;
        vec_t v;

        idle_inputs();
        rst = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 32; i++) model_dt[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_rf_en", 32'(oRF_en), 32'd0);
        chk("reset_st_en", 32'(oLSB_st_en), 32'd0);
        chk("reset_clr", 32'(oclr), 32'd0);
        chk("reset_pc", oIF_pc, 32'd0);
        chk("reset_rd_nick", 32'(oRF_rd_nick), 32'd0);
        chk("reset_full", 32'(oDP_full), 32'd0);
        chk("reset_nick", 32'(oDP_nick), 32'd1);

        //           en rd wr br pd st  cen cn cdt          ctk ctgt   nick full nen
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0,           0, 0,     1, 0, 1));
        tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0,           0, 0,     2, 0, 1));
        tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0,           0, 0,     3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h1234,    0, 0,     4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 32'h3333,    0, 0,     4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0,     4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0,     4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 32'h2222,    0, 0,     4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0,     4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0,     4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0,     4, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0,           0, 0,     4, 0, 0));
        tbl.push_back(mk(1, 9, 0, 0, 0, 1, 0, 0, 0,           0, 0,     5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 32'h44,      0, 0,     6, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0,           0, 0,     6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 32'h0,       1, 32'h999, 7, 0, 0));
        tbl.push_back(mk(1, 31, 1, 0, 0, 0, 0, 0, 0,          0, 0,     7, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 32'hdeadbeef, 0, 0,    8, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0,     8, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0,     8, 0, 0));

        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v);
            #1;
            chk($sformatf("tbl%0d_nick", i), 32'(oDP_nick), 32'(v.exp_nick));
            chk($sformatf("tbl%0d_full", i), 32'(oDP_full), 32'(v.exp_full));
            chk($sformatf("tbl%0d_nick_en", i), 32'(oRF_nick_en), 32'(v.exp_nen));
            if (v.exp_nen) begin
                chk($sformatf("tbl%0d_nick_regnm", i), 32'(oRF_nick_regnm), 32'(v.rd));
                chk($sformatf("tbl%0d_rf_nick", i), 32'(oRF_nick), 32'(v.exp_nick));
            end
            if (v.en && (v.st || (v.wr && v.rd != 0))) push(v.st, v.rd, v.exp_nick);
            tick();
        end
        idle_inputs();
        drain(20);

        // Reset while a ready head is about to commit: nothing retires.
        dispatch(3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_nick", 32'(oDP_nick), 32'd8);
        push(1'b0, 3, 8);
        tick();
        cdb(8, 32'h88, 1'b0, 32'h0);
        tick();
        do_reset(1'b0);
        chk("mid_rst_rf_en", 32'(oRF_en), 32'd0);
        chk("mid_rst_clr", 32'(oclr), 32'd0);
        chk("mid_rst_nick", 32'(oDP_nick), 32'd1);
        chk("mid_rst_full", 32'(oDP_full), 32'd0);
        tick();
        chk("mid_rst_late_rf_en", 32'(oRF_en), 32'd0);

        // Fill all slots, try one more, then free the oldest and wrap.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            dispatch(i + 1, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("fill%0d_nick", i), 32'(oDP_nick), 32'(i + 1));
            chk($sformatf("fill%0d_full", i), 32'(oDP_full), 32'd0);
            push(1'b0, i + 1, i + 1);
            tick();
        end
        dispatch(20, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full_flag", 32'(oDP_full), 32'd1);
        chk("full_no_alloc", 32'(oRF_nick_en), 32'd0);
        tick();
        cdb(1, 32'h1111, 1'b0, 32'h0);
        tick();
        idle_inputs();
        rdy = 1'b0;
        iDP_en = 1'b1; iDP_rd_regnm = 5'd21; iDP_wr_rd = 1'b1;
        #1;
        chk("frozen_no_alloc", 32'(oRF_nick_en), 32'd0);
        tick();
        chk("frozen_no_commit0", 32'(oRF_en), 32'd0);
        tick();
        chk("frozen_no_commit1", 32'(oRF_en), 32'd0);
        rdy = 1'b1;
        #1;
        chk("commit_cycle_still_full", 32'(oDP_full), 32'd1);
        chk("commit_cycle_no_alloc", 32'(oRF_nick_en), 32'd0);
        tick();
        chk("commit_after_freeze", 32'(oRF_en), 32'd1);
        dispatch(22, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("wrap_full_clear", 32'(oDP_full), 32'd0);
        chk("wrap_nick", 32'(oDP_nick), 32'd1);
        chk("wrap_nick_en", 32'(oRF_nick_en), 32'd1);
        push(1'b0, 22, 1);
        tick();
        for (int unsigned i = 2; i <= DEPTH; i++) begin
            cdb(i, i * 32'h01010101, 1'b0, 32'h0);
            tick();
        end
        cdb(1, 32'habc, 1'b0, 32'h0);
        tick();
        idle_inputs();
        drain(30);

        // Mispredicted branch at head with two completed younger entries.
        do_reset(1'b1);
        dispatch(0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br_nick", 32'(oDP_nick), 32'd1);
        tick();
        dispatch(10, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 10, 2);
        tick();
        dispatch(11, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 11, 3);
        tick();
        cdb(2, 32'ha, 1'b0, 32'h0);
        tick();
        cdb(3, 32'hb, 1'b0, 32'h0);
        tick();
        idle_inputs();
        tick();
        tick();
        chk("younger_wait_for_branch", 32'(oRF_en), 32'd0);
        clr_ok = 1'b1;
        cdb(1, 32'h0, 1'b1, 32'h100);
        tick();
        idle_inputs();
        n = 0;
        while (oclr !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("flush_latency", n, 32'd1);
        chk("flush_clr", 32'(oclr), 32'd1);
        chk("flush_pc", oIF_pc, 32'h100);
        chk("flush_no_rf_en", 32'(oRF_en), 32'd0);
        dispatch(12, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush_blocks_alloc", 32'(oRF_nick_en), 32'd0);
        tick();
        chk("flush_one_cycle", 32'(oclr), 32'd0);
        clr_ok = 1'b0;
        dispatch(12, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_flush_nick", 32'(oDP_nick), 32'd1);
        chk("post_flush_nick_en", 32'(oRF_nick_en), 32'd1);
        push(1'b0, 12, 1);
        tick();
        cdb(1, 32'hc, 1'b0, 32'h0);
        tick();
        idle_inputs();
        drain(10);
        repeat (4) tick();
        chk("flush_count", clr_seen, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
